// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, digit indices and converter state type for the digit scanner
package display_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 4;
    localparam int SEL_W      = 2;

    localparam logic [SEL_W-1:0] DIG_ONES     = 2'd0;
    localparam logic [SEL_W-1:0] DIG_TENS     = 2'd1;
    localparam logic [SEL_W-1:0] DIG_HUNDREDS = 2'd2;

    typedef enum logic {
        IDLE,
        CONVERT
    } conv_state_t;

    // Digit rotation order ones -> tens -> hundreds -> ones; index 3 is never produced.
    function automatic logic [SEL_W-1:0] next_select(input logic [SEL_W-1:0] sel);
        return (sel == DIG_HUNDREDS) ? DIG_ONES : sel + 2'd1;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - multi-cycle saturating binary to 3-digit BCD double-dabble engine
module bcd_converter
    import display_pkg::*;
#(
    parameter int VALUE_W   = 10,
    parameter int MAX_VALUE = 999
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [VALUE_W-1:0]          bin_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_DIGITS*BCD_W-1:0] bcd_out
);

    localparam int BCD_BITS = NUM_DIGITS * BCD_W;
    localparam int WORK_W   = BCD_BITS + VALUE_W;
    localparam int CNT_W    = $clog2(VALUE_W + 1);
    localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

    conv_state_t       state, state_next;
    logic [WORK_W-1:0] work, work_next, stepped;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              last_step;

    // Nibble correction happens before the shift, both inside one cycle.
    always_comb begin
        logic [WORK_W-1:0] corrected;
        corrected = work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (work[VALUE_W + i*BCD_W +: BCD_W] >= BCD_W'(5)) begin
                corrected[VALUE_W + i*BCD_W +: BCD_W] = work[VALUE_W + i*BCD_W +: BCD_W] + BCD_W'(3);
            end
        end
        stepped = {corrected[WORK_W-2:0], 1'b0};
    end

    assign last_step = (bit_cnt == CNT_W'(VALUE_W - 1));
    assign bcd_out   = stepped[WORK_W-1 -: BCD_BITS];
    assign busy      = (state == CONVERT);

    always_comb begin
        state_next   = state;
        work_next    = work;
        bit_cnt_next = bit_cnt;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    work_next    = {BCD_BITS'(0), (bin_in > MAX_V) ? MAX_V : bin_in};
                    bit_cnt_next = '0;
                    state_next   = CONVERT;
                end
            end
            CONVERT: begin
                work_next    = stepped;
                bit_cnt_next = bit_cnt + 1'b1;
                if (last_step) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work    <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            work    <= work_next;
            bit_cnt <= bit_cnt_next;
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - 3-digit seven-segment scan source with refresh counter and shadowed BCD digits
module digit_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int VALUE_W     = 10,
    parameter int MAX_VALUE   = 999
) (
    input  logic               src_clk,
    input  logic               src_rst,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_load,
    output logic               busy,
    output logic [SEL_W-1:0]   select,
    output logic [BCD_W-1:0]   digit_val
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]                  refresh_cnt;
    logic                              wrap;
    logic [SEL_W-1:0]                  select_next;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  shadow;
    logic [BCD_W-1:0]                  digit_mux;
    logic                              conv_done;
    logic [NUM_DIGITS*BCD_W-1:0]       conv_bcd;

    bcd_converter #(
        .VALUE_W   (VALUE_W),
        .MAX_VALUE (MAX_VALUE)
    ) u_conv (
        .clk     (src_clk),
        .rst     (src_rst),
        .start   (value_load),
        .bin_in  (value_in),
        .busy    (busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign wrap        = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign select_next = wrap ? next_select(select) : select;

    // digit_val tracks select_next so both outputs move on the same edge.
    always_comb begin
        digit_mux = '0;
        case (select_next)
            DIG_ONES:     digit_mux = shadow[0];
            DIG_TENS:     digit_mux = shadow[1];
            DIG_HUNDREDS: digit_mux = shadow[2];
            default:      digit_mux = '0;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            refresh_cnt <= '0;
            select      <= DIG_ONES;
            digit_val   <= '0;
            shadow      <= '0;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            select      <= select_next;
            digit_val   <= digit_mux;
            if (conv_done) begin
                shadow <= conv_bcd;
            end
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// tb/tb_digit_scanner.sv - randomized self-checking bench for digit_scanner against a behavioural display model
module tb_digit_scanner;

    localparam int R    = 4;
    localparam int VW   = 10;
    localparam int MAXV = 999;

    logic          src_clk = 1'b0;
    logic          src_rst;
    logic [VW-1:0] value_in;
    logic          value_load;
    logic          busy;
    logic [1:0]    select;
    logic [3:0]    digit_val;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 src_clk = ~src_clk;

    digit_scanner #(
        .REFRESH_DIV (R),
        .VALUE_W     (VW),
        .MAX_VALUE   (MAXV)
    ) dut (
        .src_clk    (src_clk),
        .src_rst    (src_rst),
        .value_in   (value_in),
        .value_load (value_load),
        .busy       (busy),
        .select     (select),
        .digit_val  (digit_val)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int digit_of(input int v, input int s);
        case (s)
            0:       return v % 10;
            1:       return (v / 10) % 10;
            default: return v / 100;
        endcase
    endfunction

    // Display model: the shown value changes only when a whole conversion finishes,
    // the scan position is a pure function of edges since reset.
    int m_tick, m_shown, m_pending, m_left, m_sel, m_dv, m_old;
    bit m_busy;
    bit m_valid = 1'b0;

    always @(posedge src_clk) begin
        if (src_rst) begin
            m_tick  = 0;
            m_shown = 0;
            m_left  = 0;
            m_sel   = 0;
            m_dv    = 0;
        end else begin
            m_old  = m_shown;
            m_tick = m_tick + 1;
            m_sel  = (m_tick / R) % 3;
            m_dv   = digit_of(m_old, m_sel);
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_shown = m_pending;
            end else if (value_load) begin
                m_pending = (int'(value_in) > MAXV) ? MAXV : int'(value_in);
                m_left    = VW;
            end
        end
        m_busy  = (m_left > 0);
        m_valid = 1'b1;
    end

    always @(negedge src_clk) begin
        if (m_valid) begin
            check("busy", int'(busy), int'(m_busy));
            check("select", int'(select), m_sel);
            check("digit_val", int'(digit_val), m_dv);
        end
    end

    task automatic load(input int v);
        @(negedge src_clk);
        value_in   = v[VW-1:0];
        value_load = 1'b1;
        @(negedge src_clk);
        value_load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge src_clk);
        end
        check("idle_bound", int'(busy), 0);
    endtask

    task automatic expect_digit(input string name, input int s, input int lit);
        for (int i = 0; i < 3*R + 2; i++) begin
            if (int'(select) == s) break;
            @(negedge src_clk);
        end
        check({name, "_sel"}, int'(select), s);
        check(name, int'(digit_val), lit);
    endtask

    task automatic expect_digits(input string tag, input int h, input int t, input int o);
        expect_digit({tag, "_ones"}, 0, o);
        expect_digit({tag, "_tens"}, 1, t);
        expect_digit({tag, "_hund"}, 2, h);
    endtask

    task automatic convert_and_show(input int v);
        load(v);
        wait_idle();
        @(negedge src_clk);
    endtask

    initial begin
        int cnt;
        int v;
        src_rst    = 1'b1;
        value_load = 1'b0;
        value_in   = '0;
        repeat (2) @(negedge src_clk);
        check("rst_busy", int'(busy), 0);
        check("rst_select", int'(select), 0);
        check("rst_digit", int'(digit_val), 0);
        src_rst = 1'b0;

        repeat (4) @(negedge src_clk);
        check("scan_1", int'(select), 1);
        repeat (4) @(negedge src_clk);
        check("scan_2", int'(select), 2);
        repeat (4) @(negedge src_clk);
        check("scan_0", int'(select), 0);

        load(487);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge src_clk);
        end
        check("busy_len_487", cnt, 10);
        check("model_487", m_shown, 487);
        @(negedge src_clk);
        expect_digits("v487", 4, 8, 7);

        convert_and_show(1023);
        expect_digits("sat", 9, 9, 9);
        convert_and_show(0);
        expect_digits("zero", 0, 0, 0);
        convert_and_show(999);
        expect_digits("max", 9, 9, 9);

        load(123);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cnt++;
            if (i == 1) begin
                value_in   = 10'd456;
                value_load = 1'b1;
            end
            if (i == 2) value_load = 1'b0;
            @(negedge src_clk);
        end
        value_load = 1'b0;
        check("busy_len_overlap", cnt, 10);
        @(negedge src_clk);
        expect_digits("v123", 1, 2, 3);

        load(500);
        repeat (4) @(negedge src_clk);
        check("mid_busy", int'(busy), 1);
        src_rst = 1'b1;
        @(negedge src_clk);
        check("abort_busy", int'(busy), 0);
        check("abort_digit", int'(digit_val), 0);
        src_rst = 1'b0;
        repeat (15) @(negedge src_clk);
        check("model_no_commit", m_shown, 0);
        expect_digits("abort", 0, 0, 0);

        for (int i = 0; i < 3*R + 2; i++) begin
            if (select == 2'd2) break;
            @(negedge src_clk);
        end
        check("wait_sel2", int'(select), 2);
        @(negedge src_clk);
        load(42);
        wait_idle();
        @(negedge src_clk);
        expect_digits("v42", 0, 4, 2);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                @(negedge src_clk);
                src_rst = 1'b1;
                @(negedge src_clk);
                src_rst = 1'b0;
            end
            repeat ($urandom_range(0, 12)) @(negedge src_clk);
            if ($urandom_range(0, 3) == 0) v = $urandom_range(1000, 1023);
            else v = $urandom_range(0, 999);
            load(v);
        end
        wait_idle();
        repeat (20) @(negedge src_clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
